// File: rtl/cla_add_arbiter.sv
// Round-robin front end that shares one registered 5-bit CLA adder among NREQ
// requesters and tags each result with its issuing requester id.
module cla_add_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [5*NREQ-1:0] req_a,
  input  logic [5*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [4:0]        add_a,
  output logic [4:0]        add_b,
  input  logic [4:0]        add_sum,
  input  logic              add_cout,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [4:0]        rsp_sum,
  output logic              rsp_cout,
  output logic [15:0]       stat_ops,
  output logic [15:0]       stat_carry
);

  logic [IDW-1:0]            last_q, last_d;
  logic [NREQ-1:0]           gnt;
  logic [IDW-1:0]            gnt_id;
  logic                      accept;
  logic [1:0]                vld_pipe_q;
  logic [1:0][IDW-1:0]       id_pipe_q;
  logic [15:0]               ops_q, ops_d, carry_q, carry_d;

  // Search begins one past the last grant so every requester gets a turn.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    accept = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      logic [IDW-1:0] idx;
      idx = IDW'((int'(last_q) + k) % NREQ);
      if (!accept && req_valid[idx] && !rst) begin
        accept   = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

  always_comb begin
    add_a = 5'b0;
    add_b = 5'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        add_a = req_a[5*i +: 5];
        add_b = req_b[5*i +: 5];
      end
    end
  end

  always_comb begin
    last_d  = accept ? gnt_id : last_q;
    ops_d   = (accept && ops_q != 16'hFFFF) ? ops_q + 16'd1 : ops_q;
    carry_d = (rsp_valid && add_cout && carry_q != 16'hFFFF) ? carry_q + 16'd1 : carry_q;
  end

  // Tag pipeline mirrors the adder's input and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= IDW'(NREQ-1);
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
      ops_q      <= '0;
      carry_q    <= '0;
    end else begin
      last_q       <= last_d;
      vld_pipe_q   <= {vld_pipe_q[0], accept};
      id_pipe_q[0] <= gnt_id;
      id_pipe_q[1] <= id_pipe_q[0];
      ops_q        <= ops_d;
      carry_q      <= carry_d;
    end
  end

  // Gated by rst so stale in-flight results never surface in the reset cycle.
  assign rsp_valid  = vld_pipe_q[1] && !rst;
  assign rsp_id     = rst ? '0 : id_pipe_q[1];
  assign rsp_sum    = add_sum;
  assign rsp_cout   = add_cout;
  assign req_ready  = gnt;
  assign stat_ops   = ops_q;
  assign stat_carry = carry_q;

endmodule

// Two-register 5-bit carry-lookahead adder: operands registered, then result.
module cla_adder_5bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] a,
  input  logic [4:0] b,
  output logic [4:0] sum,
  output logic       cout
);

  logic [4:0] a_q, b_q, g, p, sum_d;
  logic [5:0] c;

  // Each carry is a flat sum of generate terms, not a ripple chain.
  always_comb begin
    g = a_q & b_q;
    p = a_q ^ b_q;
    c = '0;
    for (int i = 0; i < 5; i++) begin
      logic t;
      c[i+1] = 1'b0;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int m = j + 1; m <= i; m++) t = t & p[m];
        c[i+1] = c[i+1] | t;
      end
    end
    sum_d = p ^ c[4:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      a_q  <= a;
      b_q  <= b;
      sum  <= sum_d;
      cout <= c[5];
    end
  end

endmodule

// File: tb/tb_cla_add_arbiter.sv
// Directed bench: driver pushes expected responses with a due cycle, monitor pops and compares.
module tb_cla_add_arbiter;

  localparam int NREQ = 4;

  logic        clk, rst;
  logic [3:0]  req_valid, req_ready;
  logic [19:0] req_a, req_b;
  logic [4:0]  add_a, add_b, add_sum;
  logic        add_cout;
  logic        rsp_valid, rsp_cout;
  logic [1:0]  rsp_id;
  logic [4:0]  rsp_sum;
  logic [15:0] stat_ops, stat_carry;

  cla_add_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .add_cout(add_cout), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .stat_ops(stat_ops), .stat_carry(stat_carry)
  );

  cla_adder_5bit u_add (
    .clk(clk), .rst(rst), .a(add_a), .b(add_b), .sum(add_sum), .cout(add_cout)
  );

  typedef struct {
    int         id;
    logic [4:0] sum;
    logic       cout;
    int         due;
  } exp_t;

  exp_t        q[$];
  int          nvec = 0, nfail = 0, cyc = 0;
  logic [15:0] exp_ops = 0, exp_carry = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle rsp_valid must match whether an entry is due now.
  always @(negedge clk) begin
    if (rst) begin
      chk("rsp_valid_rst", 32'(rsp_valid), 0);
      chk("rsp_id_rst", 32'(rsp_id), 0);
      q.delete();
    end else begin
      while (q.size() > 0 && q[0].due < cyc) begin
        chk("rsp_missing", 0, 1);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
        chk("rsp_cout", 32'(rsp_cout), 32'(e.cout));
      end else begin
        chk("rsp_bubble", 32'(rsp_valid), 0);
      end
    end
  end

  // eid is the hand-derived grant for this cycle, -1 when nobody should win.
  task automatic drive(input logic [3:0] v, input logic [19:0] a, input logic [19:0] b,
                       input int eid);
    logic [3:0] want;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    want      = (eid < 0) ? 4'b0 : 4'(1 << eid);
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(want));
    if (eid >= 0) begin
      exp_t       e;
      logic [5:0] s;
      s     = {1'b0, a[5*eid +: 5]} + {1'b0, b[5*eid +: 5]};
      e.id  = eid;
      e.sum = s[4:0];
      e.cout = s[5];
      e.due = cyc + 2;
      q.push_back(e);
      if (exp_ops != 16'hFFFF) exp_ops++;
      if (s[5] && exp_carry != 16'hFFFF) exp_carry++;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(4'b0, 20'b0, 20'b0, -1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("ready_in_rst", 32'(req_ready), 0);
      if (i > 0) begin
        chk("ops_in_rst", 32'(stat_ops), 0);
        chk("carry_in_rst", 32'(stat_carry), 0);
      end
      @(posedge clk); #1;
    end
    rst       = 1'b0;
    exp_ops   = 0;
    exp_carry = 0;
  endtask

  task automatic check_stats();
    @(negedge clk);
    chk("stat_ops", 32'(stat_ops), 32'(exp_ops));
    chk("stat_carry", 32'(stat_carry), 32'(exp_carry));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [19:0] a, b;
    rst = 1'b1; req_valid = 4'hF; req_a = '0; req_b = '0;
    do_reset(2);

    // Rotation with all four always valid; first grant goes to requester 0.
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++) begin
        a[5*j +: 5] = 5'(7*j + 3*k + 5);
        b[5*j +: 5] = 5'(9*j + 11*k + 13);
      end
      drive(4'hF, a, b, k % 4);
    end
    idle(3);
    check_stats();

    // 19 + 15 = 34 -> sum 2, carry 1
    a = '0; b = '0; a[14:10] = 5'd19; b[14:10] = 5'd15;
    drive(4'b0100, a, b, 2);
    idle(3);
    check_stats();

    // Skipping and an idle gap that must not move the pointer.
    a = {5'd3, 5'd0, 5'd30, 5'd0}; b = {5'd29, 5'd0, 5'd1, 5'd0};
    drive(4'b0010, a, b, 1);
    drive(4'b1010, a, b, 3);
    drive(4'b1010, a, b, 1);
    idle(1);
    drive(4'b1010, a, b, 3);
    drive(4'b1010, a, b, 1);
    idle(3);

    // Mid-flight reset discards two in-flight ops.
    a = {5'd0, 5'd0, 5'd31, 5'd17}; b = {5'd0, 5'd0, 5'd1, 5'd20};
    drive(4'b0001, a, b, 0);
    drive(4'b0010, a, b, 1);
    q.delete();
    do_reset(1);
    idle(2);
    drive(4'hF, {5'd9, 5'd8, 5'd7, 5'd6}, {5'd1, 5'd2, 5'd3, 5'd4}, 0);
    idle(3);
    check_stats();

    // Exhaustive arithmetic, one lone requester per cycle.
    for (int i = 0; i < 1024; i++) begin
      int id;
      id = (i * 3 + 1) % 4;
      a = '0; b = '0;
      a[5*id +: 5] = 5'(i >> 5);
      b[5*id +: 5] = 5'(i);
      drive(4'(1 << id), a, b, id);
    end
    idle(3);
    check_stats();

    // Carry every cycle until both counters pin at FFFF.
    a = {4{5'd31}}; b = {4{5'd31}};
    for (int i = 0; i < 65536; i++) drive(4'(1 << (i % 4)), a, b, i % 4);
    idle(3);
    check_stats();
    chk("ops_sat", 32'(stat_ops), 32'hFFFF);
    chk("carry_sat", 32'(stat_carry), 32'hFFFF);
    drive(4'b0001, a, b, 0);
    idle(3);
    chk("ops_sat_hold", 32'(stat_ops), 32'hFFFF);
    chk("carry_sat_hold", 32'(stat_carry), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
